// File: rtl/triangle_assembler_pkg.sv
// Shared graphics types: vertex position, vertex color and the assembled triangle.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
//
// triangle_t is also the storage word of the triangle FIFO. Its packing order
// {v, c, id} is relied on by consumers that flatten it onto output buses.
package graphics_pkg;

    typedef logic [2:0][31:0] vertex_t;   // x, y, z words, opaque to this stage
    typedef logic [11:0]      color_t;    // RGB444

    typedef struct packed {
        vertex_t [2:0] v;                 // index 0 = first vertex to arrive
        color_t  [2:0] c;
        logic    [15:0] id;
    } triangle_t;

    localparam logic [15:0] CNT16_MAX = 16'hFFFF;

    // A triangle that reuses a vertex index has zero area.
    function automatic logic is_degenerate(input logic [15:0] id0,
                                           input logic [15:0] id1,
                                           input logic [15:0] id2);
        return (id0 == id1) || (id1 == id2) || (id0 == id2);
    endfunction

endpackage

// File: rtl/triangle_assembler_if.sv
// Vertex-in / triangle-out bundle between fetch, the assembler and raster setup.
// Latency: n/a (wires only).
// Backpressure: vertex side has none; triangle side uses valid_out/ready_in.
//
// master: the environment (drives vertex beats and ready_in).
// slave : the assembler (drives the triangle head, counters and overflow flag).
interface triangle_assembler_if;
    import graphics_pkg::*;

    logic           valid_in;
    logic [15:0]    vertex_id_in;
    vertex_t        vertex_in;
    color_t         color_in;
    logic           ready_in;

    logic           valid_out;
    vertex_t [2:0]  triangle_out;
    color_t  [2:0]  colors_out;
    logic [15:0]    triangle_id_out;
    logic [15:0]    degenerate_count_out;
    logic           overflow_out;

    modport master (
        output valid_in, vertex_id_in, vertex_in, color_in, ready_in,
        input  valid_out, triangle_out, colors_out, triangle_id_out,
               degenerate_count_out, overflow_out
    );

    modport slave (
        input  valid_in, vertex_id_in, vertex_in, color_in, ready_in,
        output valid_out, triangle_out, colors_out, triangle_id_out,
               degenerate_count_out, overflow_out
    );

endinterface

// File: rtl/triangle_assembler_fifo.sv
// Generic first-word-fall-through FIFO; head shows the oldest entry, zero when empty.
// Latency: a push into an empty FIFO is visible on head the next cycle.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
//
// Ports: clk_in/rst_in (sync, active high), push/push_dat, pop, full, empty, head.
// DEPTH must be a power of two >= 2 so the pointers wrap without compare logic.
module triangle_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             pop_ok, push_ok;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    // Empty head reads as zero so nothing stale leaks out after reset.
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && !empty;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        push_ok  = push && (!full || pop_ok);

        if (push_ok) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed through head, gated by empty.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/triangle_assembler.sv
// Groups every three valid vertex beats into a triangle, drops degenerate ones, queues the rest.
// Latency: triangle completed at cycle N is on valid_out at N+1 when the queue was empty.
// Backpressure: none upstream; a completion meeting a full queue with no pop is lost and sets overflow_out.
//
// Ports: clk_in, rst_in (sync, active high); bus (slave) carries vertex beats in and
// the head triangle, its ready, the degenerate counter and the sticky overflow flag out.
module triangle_assembler
    import graphics_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    triangle_assembler_if.slave  bus
);
    logic [1:0]  slot_q, slot_d;
    logic [15:0] id0_q, id0_d, id1_q, id1_d;
    vertex_t     v0_q, v0_d, v1_q, v1_d;
    color_t      c0_q, c0_d, c1_q, c1_d;
    logic [15:0] tri_seq_q, tri_seq_d;
    logic [15:0] degen_cnt_q, degen_cnt_d;
    logic        overflow_q, overflow_d;

    logic        complete, degen, push, pop;
    logic        fifo_full, fifo_empty;
    triangle_t   entry, head;

    always_comb begin
        slot_d      = slot_q;
        id0_d       = id0_q;
        id1_d       = id1_q;
        v0_d        = v0_q;
        v1_d        = v1_q;
        c0_d        = c0_q;
        c1_d        = c1_q;
        tri_seq_d   = tri_seq_q;
        degen_cnt_d = degen_cnt_q;
        overflow_d  = overflow_q;

        complete = bus.valid_in && (slot_q == 2'd2);
        degen    = complete && is_degenerate(id0_q, id1_q, bus.vertex_id_in);
        push     = complete && !degen;
        pop      = bus.ready_in && !fifo_empty;

        // Third vertex is taken straight from the bus, never registered here.
        entry.v  = {bus.vertex_in, v1_q, v0_q};
        entry.c  = {bus.color_in, c1_q, c0_q};
        entry.id = tri_seq_q;

        if (bus.valid_in) begin
            unique case (slot_q)
                2'd0: begin
                    id0_d  = bus.vertex_id_in;
                    v0_d   = bus.vertex_in;
                    c0_d   = bus.color_in;
                    slot_d = 2'd1;
                end
                2'd1: begin
                    id1_d  = bus.vertex_id_in;
                    v1_d   = bus.vertex_in;
                    c1_d   = bus.color_in;
                    slot_d = 2'd2;
                end
                default: slot_d = 2'd0;
            endcase
        end

        // Sequence numbers are consumed by dropped triangles too.
        if (complete) begin
            tri_seq_d = tri_seq_q + 16'd1;
        end
        if (degen && (degen_cnt_q != CNT16_MAX)) begin
            degen_cnt_d = degen_cnt_q + 16'd1;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_q      <= 2'd0;
            id0_q       <= '0;
            id1_q       <= '0;
            v0_q        <= '0;
            v1_q        <= '0;
            c0_q        <= '0;
            c1_q        <= '0;
            tri_seq_q   <= '0;
            degen_cnt_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            id0_q       <= id0_d;
            id1_q       <= id1_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            c0_q        <= c0_d;
            c1_q        <= c1_d;
            tri_seq_q   <= tri_seq_d;
            degen_cnt_q <= degen_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    triangle_fifo #(
        .WIDTH ($bits(triangle_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .push     (push),
        .push_dat (entry),
        .pop      (bus.ready_in),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (head)
    );

    assign bus.valid_out            = !fifo_empty;
    assign bus.triangle_out         = head.v;
    assign bus.colors_out           = head.c;
    assign bus.triangle_id_out      = head.id;
    assign bus.degenerate_count_out = degen_cnt_q;
    assign bus.overflow_out         = overflow_q;

endmodule
